dds_cmd_ctrl: RTL and testbench



---
 rtl/dds_cmd_pkg.sv | 35 +++
 rtl/dds_cmd_ctrl.sv | 156 +++++++++++++++
 tb/tb_dds_cmd_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_cmd_pkg.sv
// ============================================================================
// Module      : dds_cmd_pkg
// Description : Framing bytes, command codes and FSM states for dds_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dds_cmd_pkg;

   localparam logic [7:0] HDR_BYTE = 8'hAA;
   localparam logic [7:0] FTR_BYTE = 8'h55;

   localparam logic [7:0] CMD_FTW   = 8'h01;
   localparam logic [7:0] CMD_PHASE = 8'h02;
   localparam logic [7:0] CMD_AMP   = 8'h03;
   localparam logic [7:0] CMD_EN    = 8'h04;
   localparam logic [7:0] CMD_PRST  = 8'h05;

   localparam int unsigned PAYLOAD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_DATA   = 3'd2,
      ST_FOOTER = 3'd3,
      ST_COMMIT = 3'd4
   } state_e;

   function automatic logic is_valid_cmd(input logic [7:0] c);
      return (c >= CMD_FTW) && (c <= CMD_PRST);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dds_cmd_ctrl.sv
// ============================================================================
// Module      : dds_cmd_ctrl
// Description : UART packet parser (AA cmd p3 p2 p1 p0 55) driving DDS config.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_cmd_ctrl
   import dds_cmd_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 100_000,
   parameter logic [31:0] RESET_FTW      = 32'h0000_0000,
   parameter logic [15:0] RESET_AMP      = 16'hFFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] freq_word,
   output logic [31:0] phase_offset,
   output logic [15:0] amplitude,
   output logic        out_en,
   output logic        phase_rst,
   output logic        cfg_update,
   output logic        pkt_error,
   output logic [7:0]  err_count
);

   localparam int unsigned     TW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT_CYCLES - 1);

   if (TIMEOUT_CYCLES < 2 || CLK_HZ == 0) begin : g_param_check
      $error("dds_cmd_ctrl: TIMEOUT_CYCLES must be >= 2 and CLK_HZ non-zero");
   end

   state_e          state_q, state_d;
   logic [7:0]      cmd_q;
   logic [31:0]     shadow_q;
   logic [1:0]      byte_cnt_q;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            err_d;
   logic            timeout;
   logic            commit, wr_ftw, wr_phase, wr_amp, wr_en, wr_prst;

   logic [31:0]     freq_q, phase_q;
   logic [15:0]     amp_q;
   logic            en_q, prst_q, upd_q, err_q;
   logic [7:0]      err_cnt_q;

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   assign timeout = (state_q inside {ST_CMD, ST_DATA, ST_FOOTER}) && !rx_valid && (tmo_q == TMAX);

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         // COMMIT lasts one cycle; a byte seen then is handled as in IDLE.
         ST_IDLE, ST_COMMIT: begin
            state_d = (rx_valid && rx_data == HDR_BYTE) ? ST_CMD : ST_IDLE;
         end
         ST_CMD: begin
            if (rx_valid) begin
               state_d = is_valid_cmd(rx_data) ? ST_DATA : ST_IDLE;
               err_d   = !is_valid_cmd(rx_data);
            end else if (timeout) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               if (byte_cnt_q == 2'(PAYLOAD_BYTES - 1)) state_d = ST_FOOTER;
            end else if (timeout) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_FOOTER: begin
            if (rx_valid) begin
               state_d = (rx_data == FTR_BYTE) ? ST_COMMIT : ST_IDLE;
               err_d   = (rx_data != FTR_BYTE);
            end else if (timeout) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rx_valid || !(state_d inside {ST_CMD, ST_DATA, ST_FOOTER})) tmo_d = '0;
      else                                                            tmo_d = tmo_q + 1'b1;
   end

   always_comb begin
      commit   = (state_q == ST_COMMIT);
      wr_ftw   = commit && (cmd_q == CMD_FTW);
      wr_phase = commit && (cmd_q == CMD_PHASE);
      wr_amp   = commit && (cmd_q == CMD_AMP);
      wr_en    = commit && (cmd_q == CMD_EN);
      wr_prst  = commit && (cmd_q == CMD_PRST);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cmd_q      <= '0;
         shadow_q   <= '0;
         byte_cnt_q <= '0;
         tmo_q      <= '0;
         freq_q     <= RESET_FTW;
         phase_q    <= '0;
         amp_q      <= RESET_AMP;
         en_q       <= 1'b0;
         prst_q     <= 1'b0;
         upd_q      <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         tmo_q  <= tmo_d;
         err_q  <= err_d;
         upd_q  <= commit;
         prst_q <= wr_prst;
         if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;

         if (state_q == ST_CMD && rx_valid) begin
            cmd_q      <= rx_data;
            byte_cnt_q <= '0;
         end
         if (state_q == ST_DATA && rx_valid) begin
            shadow_q   <= {shadow_q[23:0], rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
         end

         if (wr_ftw)   freq_q  <= shadow_q;
         if (wr_phase) phase_q <= shadow_q;
         if (wr_amp)   amp_q   <= shadow_q[15:0];
         if (wr_en)    en_q    <= shadow_q[0];
      end
   end

   assign freq_word    = freq_q;
   assign phase_offset = phase_q;
   assign amplitude    = amp_q;
   assign out_en       = en_q;
   assign phase_rst    = prst_q;
   assign cfg_update   = upd_q;
   assign pkt_error    = err_q;
   assign err_count    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_cmd_ctrl.sv
// ============================================================================
// Module      : tb_dds_cmd_ctrl
// Description : Directed packet sequences with an event scoreboard for dds_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_cmd_ctrl;

   localparam int unsigned T   = 40;
   localparam int unsigned GAP = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [31:0] freq_word, phase_offset;
   logic [15:0] amplitude;
   logic        out_en, phase_rst, cfg_update, pkt_error;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        upd;
      logic        err;
      logic        prst;
      logic [31:0] ftw;
      logic [31:0] ph;
      logic [15:0] amp;
      logic        en;
      logic [7:0]  ecnt;
   } evt_t;

   evt_t sb[$];
   evt_t got;

   logic [31:0] m_ftw, m_ph;
   logic [15:0] m_amp;
   logic        m_en;
   logic [7:0]  m_err;

   dds_cmd_ctrl #(
      .CLK_HZ         (100_000_000),
      .TIMEOUT_CYCLES (T),
      .RESET_FTW      (32'h0000_0000),
      .RESET_AMP      (16'hFFFF)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .freq_word    (freq_word),
      .phase_offset (phase_offset),
      .amplitude    (amplitude),
      .out_en       (out_en),
      .phase_rst    (phase_rst),
      .cfg_update   (cfg_update),
      .pkt_error    (pkt_error),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ftw = 32'h0; m_ph = 32'h0; m_amp = 16'hFFFF; m_en = 1'b0; m_err = 8'h0;
   endtask

   task automatic expect_commit(input logic [7:0] cmd, input logic [31:0] p);
      evt_t e;
      case (cmd)
         8'h01: m_ftw = p;
         8'h02: m_ph  = p;
         8'h03: m_amp = p[15:0];
         8'h04: m_en  = p[0];
         default: ;
      endcase
      e = '{upd: 1'b1, err: 1'b0, prst: (cmd == 8'h05), ftw: m_ftw, ph: m_ph,
            amp: m_amp, en: m_en, ecnt: m_err};
      sb.push_back(e);
   endtask

   task automatic expect_error();
      evt_t e;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      e = '{upd: 1'b0, err: 1'b1, prst: 1'b0, ftw: m_ftw, ph: m_ph,
            amp: m_amp, en: m_en, ecnt: m_err};
      sb.push_back(e);
   endtask

   // Byte is sampled at the next rising edge; returns #1 after that edge plus gap cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] p,
                           input logic [7:0] ftr, input int last_gap);
      send_byte(8'hAA, GAP);
      send_byte(cmd, GAP);
      for (int i = 3; i >= 0; i--) send_byte(p[i*8 +: 8], GAP);
      send_byte(ftr, last_gap);
   endtask

   always @(negedge clk) begin
      if (resetn === 1'b1 && (cfg_update === 1'b1 || pkt_error === 1'b1 || phase_rst === 1'b1)) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_event", 32'({cfg_update, pkt_error, phase_rst}), 32'd0);
         end else begin
            got = sb.pop_front();
            chk("evt_cfg_update", 32'(cfg_update), 32'(got.upd));
            chk("evt_pkt_error",  32'(pkt_error),  32'(got.err));
            chk("evt_phase_rst",  32'(phase_rst),  32'(got.prst));
            chk("evt_freq_word",  freq_word,       got.ftw);
            chk("evt_phase_off",  phase_offset,    got.ph);
            chk("evt_amplitude",  32'(amplitude),  32'(got.amp));
            chk("evt_out_en",     32'(out_en),     32'(got.en));
            chk("evt_err_count",  32'(err_count),  32'(got.ecnt));
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      resetn   = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      chk("rst_freq_word",  freq_word,           32'h0);
      chk("rst_phase_off",  phase_offset,        32'h0);
      chk("rst_amplitude",  32'(amplitude),      32'hFFFF);
      chk("rst_out_en",     32'(out_en),         32'd0);
      chk("rst_pulses",     32'({phase_rst, cfg_update, pkt_error}), 32'd0);
      chk("rst_err_count",  32'(err_count),      32'd0);

      // FTW packet with explicit commit-latency checks around the footer edge.
      expect_commit(8'h01, 32'h028F5C28);
      send_byte(8'hAA, GAP);
      send_byte(8'h01, GAP);
      send_byte(8'h02, GAP);
      send_byte(8'h8F, GAP);
      send_byte(8'h5C, GAP);
      send_byte(8'h28, GAP);
      send_byte(8'h55, 0);
      chk("t1_upd_at_N",   32'(cfg_update), 32'd0);
      chk("t1_ftw_at_N",   freq_word,       32'h0);
      @(posedge clk); #1;
      chk("t1_upd_at_N1",  32'(cfg_update), 32'd1);
      chk("t1_ftw_at_N1",  freq_word,       32'h028F5C28);
      @(posedge clk); #1;
      chk("t1_upd_at_N2",  32'(cfg_update), 32'd0);
      repeat (GAP) begin @(posedge clk); #1; end

      // Leading junk ignored; footer followed immediately by next header (COMMIT cycle).
      send_byte(8'h00, GAP);
      send_byte(8'h13, GAP);
      expect_commit(8'h03, 32'h00001234);
      send_pkt(8'h03, 32'h00001234, 8'h55, 0);

      expect_error();
      send_pkt(8'h01, 32'h11223344, 8'h56, GAP);
      chk("t3_ftw_kept", freq_word, 32'h028F5C28);
      expect_commit(8'h04, 32'h00000001);
      send_pkt(8'h04, 32'h00000001, 8'h55, GAP);
      chk("t3_out_en", 32'(out_en), 32'd1);

      expect_error();
      send_byte(8'hAA, GAP);
      send_byte(8'h07, 0);
      chk("t4_immediate_err", 32'(pkt_error), 32'd1);
      repeat (GAP) begin @(posedge clk); #1; end
      expect_commit(8'h02, 32'hDEADBEEF);
      send_pkt(8'h02, 32'hDEADBEEF, 8'h55, GAP);
      chk("t4_phase_off", phase_offset, 32'hDEADBEEF);

      // Timeout after a stalled payload, measured from the last accepted byte.
      expect_error();
      send_byte(8'hAA, GAP);
      send_byte(8'h01, GAP);
      send_byte(8'h02, GAP);
      send_byte(8'h8F, 0);
      cnt = 0;
      while (pkt_error !== 1'b1 && cnt < int'(T) + 10) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("t5_timeout_latency", 32'(cnt), 32'(T));
      repeat (GAP) begin @(posedge clk); #1; end

      // A byte arriving exactly when the counter would expire is accepted.
      expect_commit(8'h01, 32'h12345678);
      send_byte(8'hAA, GAP);
      send_byte(8'h01, T - 1);
      send_byte(8'h12, GAP);
      send_byte(8'h34, T - 1);
      send_byte(8'h56, GAP);
      send_byte(8'h78, GAP);
      send_byte(8'h55, GAP);
      chk("t5_ftw_after_timeout", freq_word, 32'h12345678);

      // Reset in the middle of a packet.
      send_byte(8'hAA, GAP);
      send_byte(8'h01, GAP);
      send_byte(8'h02, GAP);
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      model_reset();
      chk("t6_freq_word",  freq_word,           32'h0);
      chk("t6_phase_off",  phase_offset,        32'h0);
      chk("t6_amplitude",  32'(amplitude),      32'hFFFF);
      chk("t6_out_en",     32'(out_en),         32'd0);
      chk("t6_err_count",  32'(err_count),      32'd0);
      expect_commit(8'h05, 32'h00000000);
      send_pkt(8'h05, 32'h00000000, 8'h55, GAP);

      // Drive the error counter into saturation.
      for (int i = 0; i < 260; i++) begin
         expect_error();
         send_byte(8'hAA, 0);
         send_byte(8'h07, 1);
      end
      repeat (4) begin @(posedge clk); #1; end
      chk("t7_err_saturated", 32'(err_count), 32'hFF);
      chk("t7_ftw_kept",      freq_word,      32'h0);

      repeat (10) begin @(posedge clk); #1; end
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
